// File: rtl/blink_led_core.sv
// Heartbeat LED generator: a millisecond prescaler feeds a period counter, and the
// LED is lit while the period counter is below the on-time.
module blink_led_core #(
  parameter int unsigned CLK_FREQ_HZ = 128_000_000,
  parameter int unsigned PERIOD_MS   = 1000,
  parameter int unsigned ON_MS       = 500
) (
  input  logic clk_128M,
  input  logic rst_n,
  output logic led
);

  localparam int unsigned PRESCALE = CLK_FREQ_HZ / 1000;
  localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned MS_W     = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(PERIOD_MS - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             ms_tick;
  logic             led_on_p0;

  // Stage p0: prescaler and millisecond counter
  assign ms_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (ms_tick) begin
      ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MS_W'(1);
    end
  end

  // Stage p1: registered LED, compared at 32 bits so ON_MS >= PERIOD_MS stays lit
  assign led_on_p0 = (32'(ms_cnt) < ON_MS);

  always_ff @(posedge clk_128M or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= led_on_p0;
    end
  end

endmodule

// File: tb/tb_blink_led_core.sv
// Scoreboard bench for blink_led_core: five parameter sets share one clock and
// reset; expected LED levels are queued per cycle and checked by a monitor.
module tb_blink_led_core;

  localparam int NI = 5;

  logic clk_128M;
  logic rst_n;
  logic led_basic, led_duty, led_off, led_full, led_p1;
  logic [NI-1:0] led_v;

  assign led_v = {led_p1, led_full, led_off, led_duty, led_basic};

  blink_led_core #(.CLK_FREQ_HZ(10_000), .PERIOD_MS(4), .ON_MS(1)) u_basic (
    .clk_128M(clk_128M), .rst_n(rst_n), .led(led_basic));
  blink_led_core #(.CLK_FREQ_HZ(10_000), .PERIOD_MS(4), .ON_MS(2)) u_duty (
    .clk_128M(clk_128M), .rst_n(rst_n), .led(led_duty));
  blink_led_core #(.CLK_FREQ_HZ(10_000), .PERIOD_MS(4), .ON_MS(0)) u_off (
    .clk_128M(clk_128M), .rst_n(rst_n), .led(led_off));
  blink_led_core #(.CLK_FREQ_HZ(10_000), .PERIOD_MS(4), .ON_MS(4)) u_full (
    .clk_128M(clk_128M), .rst_n(rst_n), .led(led_full));
  blink_led_core #(.CLK_FREQ_HZ(10_000), .PERIOD_MS(1), .ON_MS(1)) u_p1 (
    .clk_128M(clk_128M), .rst_n(rst_n), .led(led_p1));

  typedef struct {
    int            n;
    logic [NI-1:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;
  int   n_edge;

  initial begin
    clk_128M = 1'b0;
    forever #5 clk_128M = ~clk_128M;
  end

  function automatic string inst_name(input int i);
    case (i)
      0:       return "basic_on1";
      1:       return "duty_on2";
      2:       return "on0";
      3:       return "on_eq_period";
      default: return "period1";
    endcase
  endfunction

  // Hand-derived waveform: lit on edges 1..ON*PRE of each PERIOD*PRE-cycle period
  function automatic logic exp_led(input int n, input int pre, input int per, input int on);
    int m;
    if (n == 0) return 1'b0;
    m = (n - 1) % (per * pre);
    return (m < on * pre);
  endfunction

  function automatic logic [NI-1:0] exp_vec(input int n);
    logic [NI-1:0] v;
    v[0] = exp_led(n, 10, 4, 1);
    v[1] = exp_led(n, 10, 4, 2);
    v[2] = exp_led(n, 10, 4, 0);
    v[3] = exp_led(n, 10, 4, 4);
    v[4] = exp_led(n, 10, 1, 1);
    return v;
  endfunction

  // One clock: the edge is taken under the current reset level, then rst_n is
  // changed just after the edge, so a falling rst_n must clear led before the sample.
  task automatic cycle(input logic rst_val);
    exp_t e;
    @(posedge clk_128M);
    if (rst_n) n_edge = n_edge + 1;
    else       n_edge = 0;
    #1;
    rst_n = rst_val;
    if (!rst_val) n_edge = 0;
    e.n   = n_edge;
    e.exp = exp_vec(n_edge);
    q.push_back(e);
  endtask

  always @(negedge clk_128M) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < NI; i++) begin
        vectors = vectors + 1;
        if (led_v[i] !== mon_e.exp[i]) begin
          miscompares = miscompares + 1;
          $display("FAIL %s edge=%0d led=%b expected=%b",
                   inst_name(i), mon_e.n, led_v[i], mon_e.exp[i]);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_edge      = 0;
    rst_n       = 1'b1;
    #1;
    rst_n = 1'b0;

    // Reset held for 10 cycles with the clock running
    repeat (10) cycle(1'b0);

    // Release, then five full 40-cycle periods of the basic pattern
    cycle(1'b1);
    repeat (200) cycle(1'b1);

    // Fresh start, then a 3-cycle reset pulse right after edge 25 (led low phase)
    cycle(1'b0);
    cycle(1'b1);
    repeat (24) cycle(1'b1);
    cycle(1'b0);
    repeat (2) cycle(1'b0);
    cycle(1'b1);
    repeat (120) cycle(1'b1);

    // Reset falling while led is lit (edge 5) must clear it before the next edge
    repeat (4) cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    repeat (45) cycle(1'b1);

    @(negedge clk_128M);
    #1;
    if (q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blink_led_core.md
# blink_led_core

Free-running heartbeat LED generator for the board top level. Clocked by the 128 MHz system clock from the clock wizard. Drives one status LED with a fixed period and on-time derived from parameters, so a visibly blinking LED proves the clock tree is alive. Contains no inputs other than clock and reset.

## Interface
- CLK_FREQ_HZ, 128_000_000: clock frequency; prescale count PRESCALE = CLK_FREQ_HZ/1000 (integer division, must be ≥ 1).
- PERIOD_MS, 1000: blink period in milliseconds (≥ 1).
- ON_MS, 500: LED-on time per period in milliseconds (0 = always off, ≥ PERIOD_MS = always on).
- clk_128M  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- led  output  1  registered LED drive, 1 = lit.

## Operation
- Prescaler `pre_cnt`, width clog2(PRESCALE), range 0..PRESCALE-1.
  - Increments every cycle.
  - On reaching PRESCALE-1, wraps to 0 and asserts an internal one-cycle `ms_tick`.
- Millisecond counter `ms_cnt`, width clog2(PERIOD_MS) (min 1), range 0..PERIOD_MS-1.
  - Advances only on `ms_tick`.
  - Wraps from PERIOD_MS-1 to 0.
  - With PERIOD_MS = 1, stays at 0.
- LED register: every cycle, `led <= (ms_cnt < ON_MS)`, using the pre-edge value of `ms_cnt`.
  - The comparison is unsigned, done at 32 bits.
  - ON_MS ≥ PERIOD_MS therefore gives a constant 1 after the first clock.
- Reset (rst_n low, asynchronous): `pre_cnt` = 0, `ms_cnt` = 0, `led` = 0. All three hold while rst_n is low.
- Reset asserted mid-period: all state clears immediately, with no wait for a clock edge. The pattern restarts from the beginning of the on-phase after release.
- No other control exists; the behaviour is strictly periodic with no dependency on external events.
- Synthesizable, no latches, no initial blocks relied on for function.

## Timing
- Reset release synchronisation is the responsibility of the upstream reset conditioner. This block only requires rst_n to deassert synchronously to clk_128M.
- Edge 1 after reset release:
  - `led` becomes 1 if ON_MS > 0.
  - `led` stays 0 if ON_MS = 0.
- `ms_tick` fires on cycles PRESCALE, 2·PRESCALE, … counted from release. `ms_cnt` updates on those same edges.
- Cycle numbering: edge n is the n-th rising edge after release.
- `ms_cnt` reaches ON_MS at edge ON_MS·PRESCALE. `led` falls one edge later, at ON_MS·PRESCALE+1 (one cycle register lag).
- `ms_cnt` wraps to 0 at edge PERIOD_MS·PRESCALE. `led` rises again at PERIOD_MS·PRESCALE+1.
- Steady state:
  - led high for exactly ON_MS·PRESCALE cycles per period.
  - led low for (PERIOD_MS−ON_MS)·PRESCALE cycles per period.
  - Total period is exactly PERIOD_MS·PRESCALE cycles, with no drift.
- Default parameters: 128 000 cycles per ms; 0.5 s on, 0.5 s off.

## Test plan
- Reset value:
  - Stimulus: hold rst_n=0 for 10 cycles, clock running.
  - Required: led=0 throughout, and drops to 0 asynchronously when rst_n falls while led=1.
- Basic waveform:
  - Parameters: CLK_FREQ_HZ=10_000 (PRESCALE=10), PERIOD_MS=4, ON_MS=1.
  - Required after release:
    - led=1 from edge 1 to edge 10.
    - led=0 from edge 11 to edge 40.
    - led=1 again at edge 41.
    - Pattern repeats every 40 cycles, checked over 5 periods.
- 50 % duty:
  - Parameters: PRESCALE=10, PERIOD_MS=4, ON_MS=2.
  - Required: high 20 cycles, low 20 cycles, repeating exactly.
- Boundaries:
  - ON_MS=0: led stays 0 forever.
  - ON_MS=4 with PERIOD_MS=4: led is 1 from edge 1 and never falls over 200 cycles.
  - PERIOD_MS=1, ON_MS=1: led is constant 1.
- Mid-operation reset:
  - Stimulus: with the basic-waveform parameters, pulse rst_n low for 3 cycles at edge 25 (led=0 phase).
  - Required:
    - led=0 during reset.
    - led=1 at edge 1 after re-release.
    - Then the full 10-high / 30-low pattern with no residual phase from before the reset.
- Default parameters (long sim):
  - Required: first falling edge of led at edge 64 000 001; rising edge at edge 128 000 001.
